// File: rtl/bpsk_transceiver.sv
// BPSK modem: TX emits +/-carrier per bit, 1-cycle accept latency, tx_ready only when idle; RX correlates one frame after rx_sync.
// Optional feature macro PARITY_EN: TX appends an even-parity bit, RX checks it and reports rx_err.
module bpsk_transceiver #(
  parameter int FRAME_W = 8,
  parameter int SPB     = 16,
  parameter int SIG_W   = 12
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    en,
  input  logic [FRAME_W-1:0]      tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic signed [SIG_W-1:0] signal_out,
  output logic                    done,
  input  logic signed [SIG_W-1:0] signal_in,
  input  logic                    rx_sync,
  output logic [FRAME_W-1:0]      rx_data,
  output logic                    rx_valid,
  output logic                    rx_err
);
`ifdef PARITY_EN
  localparam int FL = FRAME_W + 1;
`else
  localparam int FL = FRAME_W;
`endif
  localparam int KW    = $clog2(SPB);
  localparam int BW    = (FL > 1) ? $clog2(FL) : 1;
  localparam int IW    = KW + BW;
  localparam int ACC_W = 2 * SIG_W + KW;
  localparam int AMP   = 2 ** (SIG_W - 1) - 1;
  localparam logic [IW-1:0] LAST = IW'(FL * SPB - 1);

  function automatic logic signed [SIG_W-1:0] carrier(input int k);
    real ph;
    ph = 2.0 * 3.14159265358979323846 * real'(k) / real'(SPB);
    return SIG_W'(int'(real'(AMP) * $sin(ph)));
  endfunction

  logic signed [SIG_W-1:0] ref_tab [SPB];
  for (genvar g = 0; g < SPB; g++) begin : g_ref
    localparam logic signed [SIG_W-1:0] REF_G = carrier(g);
    assign ref_tab[g] = REF_G;
  end

  function automatic logic signed [SIG_W-1:0] mod_sample(input logic [FL-1:0] f, input logic [IW-1:0] i);
    logic signed [SIG_W-1:0] r;
    r = ref_tab[i[KW-1:0]];
    return f[i[IW-1:KW]] ? r : -r;
  endfunction

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
  typedef enum logic {RX_IDLE, RX_RECV} rx_state_e;

  tx_state_e               tx_state_q, tx_state_d;
  logic [FL-1:0]           tx_frame_q, tx_frame_d, tx_load;
  logic [IW-1:0]           tx_idx_q, tx_idx_d, tx_idx_inc;
  logic signed [SIG_W-1:0] sig_q, sig_d;
  logic                    done_q, done_d, run_q;

`ifdef PARITY_EN
  assign tx_load = {^tx_data, tx_data};
`else
  assign tx_load = tx_data;
`endif
  assign tx_idx_inc = tx_idx_q + IW'(1);
  // run_q keeps tx_ready low while reset is held and for the first edge after release
  assign tx_ready   = run_q && en && (tx_state_q == TX_IDLE);
  assign signal_out = sig_q;
  assign done       = done_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_frame_d = tx_frame_q;
    tx_idx_d   = tx_idx_q;
    sig_d      = '0;
    done_d     = 1'b0;
    if (!en) begin
      tx_state_d = TX_IDLE;
    end else if (tx_state_q == TX_IDLE) begin
      if (tx_valid && run_q) begin
        tx_state_d = TX_SEND;
        tx_frame_d = tx_load;
        tx_idx_d   = '0;
        sig_d      = mod_sample(tx_load, '0);
      end
    end else if (tx_idx_q == LAST) begin
      tx_state_d = TX_IDLE;
      done_d     = 1'b1;
    end else begin
      tx_idx_d = tx_idx_inc;
      sig_d    = mod_sample(tx_frame_q, tx_idx_inc);
    end
  end

  rx_state_e               rx_state_q, rx_state_d;
  logic [IW-1:0]           rx_idx_q, rx_idx_d, rx_idx_cur;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_base, acc_sum;
  logic signed [2*SIG_W-1:0] prod;
  logic [FL-1:0]           rx_sh_q, rx_sh_d, rx_word;
  logic [FRAME_W-1:0]      rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d, rx_bit, rx_active;
`ifdef PARITY_EN
  logic                    rx_err_q, rx_err_d;
  assign rx_err = rx_err_q;
`else
  assign rx_err = 1'b0;
`endif
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  always_comb begin
    rx_active  = en && ((rx_state_q == RX_RECV) || rx_sync);
    rx_idx_cur = (rx_state_q == RX_RECV) ? rx_idx_q : '0;
    prod       = (2*SIG_W)'(signal_in) * (2*SIG_W)'(ref_tab[rx_idx_cur[KW-1:0]]);
    acc_base   = (rx_idx_cur[KW-1:0] == '0) ? '0 : acc_q;
    acc_sum    = acc_base + ACC_W'(prod);
    rx_bit     = !acc_sum[ACC_W-1] && (acc_sum != '0);
    rx_word    = (rx_sh_q >> 1) | (FL'(rx_bit) << (FL - 1));
    rx_state_d = rx_state_q;
    rx_idx_d   = rx_idx_q;
    acc_d      = acc_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
`ifdef PARITY_EN
    rx_err_d   = rx_err_q;
`endif
    if (!en) begin
      rx_state_d = RX_IDLE;
    end else if (rx_active) begin
      rx_state_d = RX_RECV;
      rx_idx_d   = rx_idx_cur + IW'(1);
      acc_d      = acc_sum;
      if (rx_idx_cur[KW-1:0] == KW'(SPB - 1)) rx_sh_d = rx_word;
      if (rx_idx_cur == LAST) begin
        rx_state_d = RX_IDLE;
        rx_data_d  = rx_word[FRAME_W-1:0];
        rx_valid_d = 1'b1;
`ifdef PARITY_EN
        rx_err_d   = ^rx_word;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      tx_state_q <= TX_IDLE;
      tx_frame_q <= '0;
      tx_idx_q   <= '0;
      sig_q      <= '0;
      done_q     <= 1'b0;
      run_q      <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_idx_q   <= '0;
      acc_q      <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
`ifdef PARITY_EN
      rx_err_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_frame_q <= tx_frame_d;
      tx_idx_q   <= tx_idx_d;
      sig_q      <= sig_d;
      done_q     <= done_d;
      run_q      <= 1'b1;
      rx_state_q <= rx_state_d;
      rx_idx_q   <= rx_idx_d;
      acc_q      <= acc_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
`ifdef PARITY_EN
      rx_err_q   <= rx_err_d;
`endif
    end
  end
endmodule

// File: doc/bpsk_transceiver.md
BPSK_TRANSCEIVER -- requirements
Module: bpsk_transceiver

Interface
REQ-001 SHALL have parameter FRAME_W, default 8, data bits per frame (legal 1..32).
REQ-002 SHALL have parameter SPB, default 16, samples per bit (power of two, 4..64).
REQ-003 SHALL have parameter SIG_W, default 12, signed sample width (4..16).
REQ-004 SHALL have ports: clk input 1 system clock; arst input 1 asynchronous active-low reset (asserted at 0).
REQ-005 SHALL have ports: en input 1 global enable; tx_data input FRAME_W frame to send; tx_valid input 1; tx_ready output 1.
REQ-006 SHALL have ports: signal_out output SIG_W modulated samples (two's complement); done output 1 end-of-frame pulse.
REQ-007 SHALL have ports: signal_in input SIG_W received samples; rx_sync input 1 marks sample 0 of bit 0; rx_data output FRAME_W; rx_valid output 1; rx_err output 1.

Function
REQ-008 Carrier table SHALL hold SPB entries ref[k] = round(A*sin(2*pi*k/SPB)), A = 2^(SIG_W-1)-1, computed at elaboration, one carrier period per bit.
REQ-009 TX FSM SHALL have states IDLE and SEND; tx_ready = (IDLE and en).
REQ-010 On a rising edge with tx_valid and tx_ready, TX SHALL capture tx_data, enter SEND and register sample 0 of bit 0 onto signal_out (latency 1 cycle).
REQ-011 Bits SHALL be sent LSB first, each for SPB consecutive cycles: bit 1 -> +ref[k], bit 0 -> -ref[k].
REQ-012 At the edge ending the last sample, TX SHALL return to IDLE, drive signal_out = 0 and pulse done for exactly one cycle; tx_ready SHALL be 1 in that same cycle.
REQ-013 signal_out SHALL be 0 whenever TX is IDLE; tx_data changes during SEND SHALL have no effect.
REQ-014 RX FSM SHALL have states IDLE and RECV; rx_sync with en in IDLE SHALL start RECV, with the signal_in present in that cycle treated as sample k=0.
REQ-015 RX SHALL accumulate signal_in*ref[k] per bit in a signed accumulator of 2*SIG_W+log2(SPB) bits (no overflow), cleared at k=0.
REQ-016 At k=SPB-1 the bit SHALL be 1 if the final sum > 0, else 0 (zero -> 0), shifted in LSB first.
REQ-017 After the last sample of the frame, rx_data SHALL update and rx_valid SHALL pulse one cycle on the next edge; rx_data holds until the next frame completes.
REQ-018 rx_sync during RECV SHALL be ignored.
REQ-019 en deasserted SHALL abort both FSMs to IDLE on the next edge: signal_out 0, no done, no rx_valid, rx_data unchanged.

Reset
REQ-020 arst low SHALL immediately force: both FSMs IDLE, signal_out 0, done 0, tx_ready 0, rx_data 0, rx_valid 0, rx_err 0, accumulators and counters 0.
REQ-021 Reset asserted mid-frame SHALL discard the frame; after release the first accepted frame SHALL be sent in full.

Configuration
REQ-022 Macro PARITY_EN defined: TX SHALL append an even-parity bit after the FRAME_W data bits (frame FRAME_W+1 bits); RX SHALL check it and drive rx_err = mismatch, valid only with rx_valid.
REQ-023 Macro PARITY_EN undefined: frames SHALL be FRAME_W bits; rx_err SHALL be constant 0.

Verification (FRAME_W=8, SPB=16, SIG_W=12, A=2047; T = acceptance edge)
REQ-024 Reset: arst=0 with en=1, tx_valid=1 -> signal_out=0, tx_ready=0, rx_valid=0; after arst=1, tx_ready=1.
REQ-025 Send 8'hA5, no parity -> signal_out at T+1..T+128, sample T+5 = +2047 (bit0=1), sample T+21 = -2047 (bit1=0); done=1 only at T+129, signal_out=0 then.
REQ-026 Loopback signal_in=signal_out, rx_sync at T+1 -> rx_valid=1 at T+129 with rx_data=8'hA5; repeat for 8'h00, 8'hFF.
REQ-027 PARITY_EN, send 8'h07 -> 144 samples, ninth bit +sin, rx_err=0; invert signal_in for bit 3 -> rx_data=8'h0F, rx_err=1.
REQ-028 en=0 at sample 40 of a frame -> signal_out=0 next cycle, no done, no rx_valid; en=1 -> tx_ready=1, new frame sent complete.
REQ-029 tx_valid held high with 8'h3C then 8'hC3 -> second frame accepted in done cycle, one zero sample between frames, both decoded in loopback.
